// File: rtl/clefia_sbox_seq.sv
// clefia_sbox_seq
// Time-shares one external SBOX0/SBOX1 lookup slot across the four bytes of a
// 32-bit CLEFIA F-function word (T input, already round-key xored).
//
// Ports:
//   clk, rst            clock (rising edge), synchronous active-high reset
//   in_valid/in_ready   request handshake; in_data = T word (T0 = bits 31:24)
//   in_f1               0 = F0 S-box pattern, 1 = F1 S-box pattern
//   s_x                 byte presented to both external S-boxes
//   s0_y, s1_y          SBOX0 / SBOX1 outputs for s_x
//   out_valid/out_ready result handshake; out_data = substituted word
//   busy                high while a word is being processed or held
//
// Parameter MSB_FIRST: 1 issues T0 (bits 31:24) first, 0 issues T3 first.
// Optional macro CLEFIA_SBOX_REG_EN: S-box outputs arrive one cycle after s_x
// (registered ROM); adds one drain cycle to BUSY.
module clefia_sbox_seq #(
  parameter int unsigned MSB_FIRST = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        in_f1,
  output logic [7:0]  s_x,
  input  logic [7:0]  s0_y,
  input  logic [7:0]  s1_y,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

`ifdef CLEFIA_SBOX_REG_EN
  localparam logic [2:0] LAST_IDX = 3'd4;  // 4 issue cycles + 1 drain cycle
`else
  localparam logic [2:0] LAST_IDX = 3'd3;
`endif

  state_t          r_state;
  state_t          w_state_nxt;
  logic [2:0]      r_idx;
  logic [3:0][7:0] r_data;
  logic            r_f1;
  logic [3:0][7:0] r_result;

  logic [1:0]      w_t;       // T index (0 = bits 31:24) of the byte issued now
  logic [1:0]      w_lane;    // byte lane of that T index inside the word
  logic            w_issue;
  logic            w_sel_s1;

  // Issue order mapping; the S-box choice below depends only on the T index
  assign w_t      = (MSB_FIRST != 0) ? r_idx[1:0] : ~r_idx[1:0];
  assign w_lane   = ~w_t;
  assign w_issue  = (r_state == ST_BUSY) && !r_idx[2];
  // F0: even T -> S0, odd T -> S1; F1 swaps the pair
  assign w_sel_s1 = w_t[0] ^ r_f1;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (in_valid)          w_state_nxt = ST_BUSY;
      ST_BUSY: if (r_idx == LAST_IDX) w_state_nxt = ST_DONE;
      ST_DONE: if (out_ready)         w_state_nxt = ST_IDLE;
      default:                        w_state_nxt = ST_IDLE;
    endcase
  end

  // Output decode from registered state and operands
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    s_x       = 8'h00;
    case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
      end
      ST_BUSY: begin
        if (w_issue) s_x = r_data[w_lane];
      end
      ST_DONE: begin
        out_valid = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  // Request capture and byte index
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx  <= 3'd0;
      r_data <= '0;
      r_f1   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_data <= in_data;
            r_f1   <= in_f1;
            r_idx  <= 3'd0;
          end
        end
        ST_BUSY: begin
          r_idx <= (r_idx == LAST_IDX) ? 3'd0 : r_idx + 3'd1;
        end
        default: ;
      endcase
    end
  end

`ifdef CLEFIA_SBOX_REG_EN
  logic       r_d_valid;
  logic [1:0] r_d_lane;
  logic       r_d_sel_s1;

  // S-box data for the byte issued last cycle lands now; use the delayed select
  always_ff @(posedge clk) begin
    if (rst) begin
      r_d_valid  <= 1'b0;
      r_d_lane   <= 2'd0;
      r_d_sel_s1 <= 1'b0;
      r_result   <= '0;
    end else begin
      r_d_valid  <= w_issue;
      r_d_lane   <= w_lane;
      r_d_sel_s1 <= w_sel_s1;
      if (r_d_valid) begin
        r_result[r_d_lane] <= r_d_sel_s1 ? s1_y : s0_y;
      end
    end
  end
`else
  // S-box data is combinational from s_x; capture it in the issue cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_result <= '0;
    end else if (w_issue) begin
      r_result[w_lane] <= w_sel_s1 ? s1_y : s0_y;
    end
  end
`endif

  assign out_data = r_result;

endmodule

// File: doc/clefia_sbox_seq.md
Name: clefia_sbox_seq

Overview:
Sequencer that time-shares one S0/S1 S-box lookup slot across the four bytes of a 32-bit CLEFIA F-function word.
- Accepts a 32-bit T word (already RK-xored) plus an F0/F1 select over valid/ready.
- Drives one byte per cycle to the external SBOX0/SBOX1 pair and assembles the substituted word.
- Returns the word over valid/ready.
- Sits between the round-key XOR and the M0/M1 diffusion stage, in place of four parallel S-box pairs.

Parameters:
MSB_FIRST, 1, byte issue order: 1 = byte 3 (bits 31:24) first, 0 = byte 0 (bits 7:0) first. Result byte placement is independent of this parameter.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  request valid
in_ready  output  1  block can accept a request
in_data  input  32  T word; T0 = bits 31:24 … T3 = bits 7:0
in_f1  input  1  0 = F0 pattern (T0:S0, T1:S1, T2:S0, T3:S1); 1 = F1 pattern (T0:S1, T1:S0, T2:S1, T3:S0)
s_x  output  8  byte presented to both SBOX0 and SBOX1 inputs
s0_y  input  8  SBOX0 output (combinational from s_x)
s1_y  input  8  SBOX1 output (combinational from s_x)
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_data  output  32  substituted word, same byte positions as in_data
busy  output  1  high in BUSY or DONE

Behaviour:
- One clock domain (clk). Reset is synchronous, active-high (rst). All state is registered.
- States:
  - IDLE: in_ready = 1, s_x = 0.
    - in_valid && in_ready: capture in_data and in_f1, clear idx, go to BUSY.
  - BUSY: in_ready = 0, idx runs 0..3.
    - s_x = byte selected by idx and MSB_FIRST.
    - Result byte = s0_y or s1_y, chosen by the captured in_f1 and the byte position. It is written into the result register at the clock edge ending that cycle.
    - After idx = 3, go to DONE.
  - DONE: out_valid = 1, out_data stable.
    - out_ready: go to IDLE next cycle. No same-cycle re-accept.
- Latency: handshake at edge N; s_x carries bytes in cycles N+1..N+4; out_valid rises after edge N+4 (visible in cycle N+5).
- Throughput: 1 word per 6 cycles when out_ready is held high.
- S-box selection is a pure function of the original byte index, never of issue order.
  - F0: S0 for T0/T2, S1 for T1/T3.
  - F1: S1 for T0/T2, S0 for T1/T3.
- busy = (state != IDLE).
- Reset values: state IDLE, idx 0, in_ready 1 from the first cycle after reset, out_valid 0, out_data 0x00000000, s_x 0x00, busy 0.
- Boundary conditions:
  - in_valid while BUSY/DONE is ignored; the upstream holds it.
  - out_data does not change while out_valid && !out_ready. It keeps the last result after returning to IDLE until the next result is written.
  - rst asserted mid-operation or in DONE: the request is dropped and all outputs take reset values at the next edge.
  - in_data/in_f1 changing after capture has no effect on the current operation.

Optional Feature:
CLEFIA_SBOX_REG_EN:
- Defined: the S-box outputs are treated as registered (one-cycle ROM latency).
  - The result byte for the one issued in cycle k is captured in cycle k+1, using a delayed copy of the S-box select and byte position.
  - BUSY lasts 5 cycles: 4 issue cycles, then 1 drain cycle with s_x = 0.
  - out_valid is visible in cycle N+6.
- Undefined: combinational S-box timing as described above, 4 BUSY cycles.

Test Plan:
- Bench setup for all scenarios: real SBOX0 on s0_y; S1 stub s1_y = ~s_x for deterministic values.
- Reset then idle: hold rst for 2 cycles -> in_ready = 1, out_valid = 0, out_data = 0x00000000, s_x = 0x00, busy = 0.
- F0, MSB_FIRST = 1: in_data = 0x00AD45F0, in_f1 = 0 -> s_x = 00, AD, 45, F0 in 4 consecutive cycles; out_data = 0x5752000F; out_valid in cycle N+5.
- F1: in_data = 0x00AD45F0, in_f1 = 1 -> out_data = 0xFF21BA9A.
- Backpressure: out_ready low for 10 cycles after a F0 request with in_data = 0xD6000000 -> out_data = 0xD9FF57FF held stable; in_ready = 0 and a second in_valid is ignored; raise out_ready -> IDLE, then accept the next request.
- Reset mid-operation: assert rst in the 2nd BUSY cycle -> next cycle is IDLE, out_valid = 0, out_data = 0; a subsequent request for 0x00AD45F0 (F0) completes correctly with 0x5752000F.
- MSB_FIRST = 0 and CLEFIA_SBOX_REG_EN defined with a registered SBOX0 model: in_data = 0x00AD45F0, F0 -> s_x order F0, 45, AD, 00; out_data = 0x5752000F; out_valid in cycle N+6.
